// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC tile array sequencer: FSM states, west-edge
// instruction encodings, default array geometry and a small helper.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mac_pkg;

  localparam int ROW_DEF    = 8;
  localparam int COL_DEF    = 8;
  localparam int BW_DEF     = 4;
  localparam int ADDR_W_DEF = 11;
  localparam int LEN_W_DEF  = 8;

  // West-edge instruction encodings: bit1 = execute, bit0 = kernel load
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_GAP    = 3'd2,
    S_EXEC   = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_skew.sv
// ----------------------------------------------------------------------------
// lane_skew
// Fixed-depth delay line for one west-edge lane ({inst, data}). Depth 0 is a
// plain wire so lane 0 can share the same instance pattern.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lane_skew #(
  parameter int W = 6,
  parameter int D = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (D == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_dly
    logic [W-1:0] pipe_q [D];

    // Shift register: stage 0 takes the lane input, the last stage drives out
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < D; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[D-1];
  end

endmodule

`default_nettype wire

// File: rtl/mac_array_ctrl.sv
// ----------------------------------------------------------------------------
// mac_array_ctrl
// Sequencer for the weight-stationary MAC array west edge: loads COL kernel
// words, streams x_len activation vectors, drains the pipeline, pulses done.
// Optional feature macro: MAC_ARRAY_CTRL_SKEW_EN (per-lane delay lines inside;
// when undefined, lanes are driven aligned and DRAIN is ROW-1 cycles shorter).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int ROW    = ROW_DEF,
  parameter int COL    = COL_DEF,
  parameter int BW     = BW_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   w_base_i,
  input  logic [ADDR_W-1:0]   x_base_i,
  input  logic [LEN_W-1:0]    x_len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                sram_cen_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  input  logic [ROW*BW-1:0]   sram_rdata_i,
  output logic [ROW*BW-1:0]   in_w_o,
  output logic [2*ROW-1:0]    inst_w_o
);

  // DRAIN covers the array flush (ROW+COL with skew) plus the two cycles the
  // last EXEC read spends in SRAM latency and the output register.
`ifdef MAC_ARRAY_CTRL_SKEW_EN
  localparam int DRAIN_LEN = ROW + COL + 2;
`else
  localparam int DRAIN_LEN = COL + 3;
`endif
  localparam int CNT_W = $clog2(max_int(max_int(COL, DRAIN_LEN), (1 << LEN_W) - 1) + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic [ADDR_W-1:0]   w_base_q, x_base_q;
  logic [LEN_W-1:0]    x_len_q;
  logic                vld_q;
  logic [1:0]          kind_q;
  logic [ROW*BW-1:0]   data_q;
  logic [1:0]          inst_q;

  assign cnt_inc = cnt_q + 1'b1;

  // FSM state and phase counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Run parameters captured only when a start is accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_base_q <= '0;
      x_base_q <= '0;
      x_len_q  <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      w_base_q <= w_base_i;
      x_base_q <= x_base_i;
      x_len_q  <= x_len_i;
    end
  end

  // Next-state, SRAM request and status outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sram_cen_o  = 1'b1;
    sram_addr_o = '0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        cnt_d  = '0;
        if (start_i) state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        sram_cen_o  = 1'b0;
        sram_addr_o = w_base_q + ADDR_W'(cnt_q);
        cnt_d       = cnt_inc;
        if (cnt_inc == CNT_W'(COL)) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d   = '0;
        state_d = (x_len_q != '0) ? S_EXEC : S_DRAIN;
      end
      S_EXEC: begin
        sram_cen_o  = 1'b0;
        sram_addr_o = x_base_q + ADDR_W'(cnt_q);
        cnt_d       = cnt_inc;
        if (cnt_inc == CNT_W'(x_len_q)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_W'(DRAIN_LEN)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_o  = 1'b0;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output stage: data is taken when the delayed read-valid says the SRAM word
  // is present; otherwise the data holds and the instruction goes idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      kind_q <= INST_IDLE;
      data_q <= '0;
      inst_q <= INST_IDLE;
    end else begin
      vld_q  <= ~sram_cen_o;
      kind_q <= (state_q == S_EXEC) ? INST_EXEC : INST_LOAD;
      if (vld_q) begin
        data_q <= sram_rdata_i;
        inst_q <= kind_q;
      end else begin
        inst_q <= INST_IDLE;
      end
    end
  end

`ifdef MAC_ARRAY_CTRL_SKEW_EN
  for (genvar r = 0; r < ROW; r++) begin : g_lane
    logic [BW+1:0] lane_w;
    lane_skew #(
      .W (BW + 2),
      .D (r)
    ) u_skew (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    ({inst_q, data_q[r*BW +: BW]}),
      .q_o    (lane_w)
    );
    assign inst_w_o[2*r +: 2] = lane_w[BW+1:BW];
    assign in_w_o[r*BW +: BW] = lane_w[BW-1:0];
  end
`else
  assign in_w_o   = data_q;
  assign inst_w_o = {ROW{inst_q}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_array_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mac_array_ctrl
// Self-checking bench for mac_array_ctrl with a behavioural SRAM and
// address / lane-0 scoreboards.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mac_array_ctrl;
  import mac_pkg::*;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int BW  = 4;
  localparam int AW  = 11;
  localparam int LW  = 8;
`ifdef MAC_ARRAY_CTRL_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif
  localparam logic [ROW*BW-1:0] LMASK = (SKEW != 0) ? {{(ROW-1)*BW{1'b0}}, {BW{1'b1}}} : '1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     w_base, x_base;
  logic [LW-1:0]     x_len;
  logic              busy, done, sram_cen;
  logic [AW-1:0]     sram_addr;
  logic [ROW*BW-1:0] sram_rdata = '0;
  logic [ROW*BW-1:0] in_w;
  logic [2*ROW-1:0]  inst_w;

  int n_pass   = 0;
  int n_total  = 0;
  int done_cnt = 0;
  bit saw_exec = 1'b0;

  logic [AW-1:0]       q_addr [$];
  logic [ROW*BW+1:0]   q_lane [$];

  always #5 clk = ~clk;

  mac_array_ctrl #(
    .ROW(ROW), .COL(COL), .BW(BW), .ADDR_W(AW), .LEN_W(LW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .w_base_i     (w_base),
    .x_base_i     (x_base),
    .x_len_i      (x_len),
    .busy_o       (busy),
    .done_o       (done),
    .sram_cen_o   (sram_cen),
    .sram_addr_o  (sram_addr),
    .sram_rdata_i (sram_rdata),
    .in_w_o       (in_w),
    .inst_w_o     (inst_w)
  );

  function automatic logic [ROW*BW-1:0] mem_f(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5C30F69;
  endfunction

  function automatic int exp_cycles(input int xl);
    return COL + 1 + xl + ROW + COL + 3 - ((SKEW != 0) ? 0 : ROW - 1);
  endfunction

  // Synchronous-read SRAM: data valid the cycle after cen is sampled low
  always @(posedge clk) begin
    if (!sram_cen) sram_rdata <= mem_f(sram_addr);
  end

  // Scoreboard monitor: read addresses and lane-0 west-edge words
  always @(negedge clk) begin
    if (rst_n) begin
      if (done === 1'b1) done_cnt++;
      for (int r = 0; r < ROW; r++)
        if (inst_w[2*r +: 2] == INST_EXEC) saw_exec = 1'b1;
      if (sram_cen === 1'b0) begin
        n_total++;
        if (q_addr.size() == 0) begin
          $display("FAIL read_addr: unexpected read at %0h, none pending", sram_addr);
        end else begin
          logic [AW-1:0] ea;
          ea = q_addr.pop_front();
          if (sram_addr !== ea) $display("FAIL read_addr: got %0h want %0h", sram_addr, ea);
          else n_pass++;
        end
      end
      if (inst_w[1:0] !== INST_IDLE) begin
        n_total++;
        if (q_lane.size() == 0) begin
          $display("FAIL lane0: unexpected inst %0b data %0h", inst_w[1:0], in_w);
        end else begin
          logic [ROW*BW+1:0] el;
          el = q_lane.pop_front();
          if (inst_w[1:0] !== el[ROW*BW+1:ROW*BW] || (in_w & LMASK) !== (el[ROW*BW-1:0] & LMASK))
            $display("FAIL lane0: got inst %0b data %0h want inst %0b data %0h",
                     inst_w[1:0], in_w & LMASK, el[ROW*BW+1:ROW*BW], el[ROW*BW-1:0] & LMASK);
          else n_pass++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start (held for 'hold' edges) and load the expected traffic
  task automatic launch(input logic [AW-1:0] wb, input logic [AW-1:0] xb,
                        input logic [LW-1:0] xl, input int hold);
    logic [AW-1:0] a;
    w_base = wb;
    x_base = xb;
    x_len  = xl;
    start  = 1'b1;
    for (int k = 0; k < COL; k++) begin
      a = wb + AW'(k);
      q_addr.push_back(a);
      q_lane.push_back({INST_LOAD, mem_f(a)});
    end
    for (int i = 0; i < int'(xl); i++) begin
      a = xb + AW'(i);
      q_addr.push_back(a);
      q_lane.push_back({INST_EXEC, mem_f(a)});
    end
    repeat (hold) step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 1000) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; w_base = '0; x_base = '0; x_len = '0;
    repeat (3) step();
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else n_pass++;
    n_total++; if (sram_cen !== 1'b1) $display("FAIL rst_cen: got %0b want 1", sram_cen); else n_pass++;
    n_total++; if (sram_addr !== '0) $display("FAIL rst_addr: got %0h want 0", sram_addr); else n_pass++;
    n_total++; if (in_w !== '0 || inst_w !== '0)
      $display("FAIL rst_west: got in_w %0h inst_w %0h want 0 0", in_w, inst_w); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int cyc;
    launch(11'h010, 11'h100, 8'd4, 1);
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %0b want 1", busy); else n_pass++;
    wait_done(1, cyc);
    n_total++; if (cyc != exp_cycles(4)) $display("FAIL basic_len: got %0d want %0d", cyc, exp_cycles(4)); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %0b want 0", busy); else n_pass++;
    step();
    n_total++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %0b want 0", done); else n_pass++;
    n_total++; if (q_addr.size() != 0 || q_lane.size() != 0)
      $display("FAIL basic_drain: got %0d/%0d pending want 0/0", q_addr.size(), q_lane.size()); else n_pass++;
  endtask

  task automatic test_skew();
    int c, f0, fl, cyc;
    f0 = -1; fl = -1;
    launch(11'h030, 11'h140, 8'd2, 1);
    c = 1;
    while (c < 20) begin
      if (f0 < 0 && inst_w[1:0] == INST_LOAD) f0 = c;
      if (fl < 0 && inst_w[2*ROW-1 -: 2] == INST_LOAD) fl = c;
      step();
      c++;
    end
    n_total++; if (f0 != 3) $display("FAIL skew_lane0: got %0d want 3", f0); else n_pass++;
    n_total++; if (fl != 3 + SKEW * (ROW - 1))
      $display("FAIL skew_lane_last: got %0d want %0d", fl, 3 + SKEW * (ROW - 1)); else n_pass++;
    wait_done(c, cyc);
    n_total++; if (cyc != exp_cycles(2)) $display("FAIL skew_len: got %0d want %0d", cyc, exp_cycles(2)); else n_pass++;
    step();
  endtask

  task automatic test_zero_len();
    int cyc;
    saw_exec = 1'b0;
    launch(11'h020, 11'h200, 8'd0, 1);
    wait_done(1, cyc);
    n_total++; if (cyc != exp_cycles(0)) $display("FAIL zero_len: got %0d want %0d", cyc, exp_cycles(0)); else n_pass++;
    repeat (2 * ROW) step();
    n_total++; if (saw_exec !== 1'b0) $display("FAIL zero_exec: got %0b want 0", saw_exec); else n_pass++;
    n_total++; if (q_addr.size() != 0 || q_lane.size() != 0)
      $display("FAIL zero_drain: got %0d/%0d pending want 0/0", q_addr.size(), q_lane.size()); else n_pass++;
  endtask

  task automatic test_start_filter();
    int cyc, d0;
    d0 = done_cnt;
    launch(11'h060, 11'h160, 8'd5, 3);
    repeat (COL) step();
    w_base = 11'h3AA; x_base = 11'h555; x_len = 8'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(COL + 4, cyc);
    n_total++; if (cyc != exp_cycles(5)) $display("FAIL filt_len: got %0d want %0d", cyc, exp_cycles(5)); else n_pass++;
    repeat (40) step();
    n_total++; if (done_cnt - d0 != 1) $display("FAIL filt_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL filt_idle: got busy %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_wrap();
    int cyc;
    launch(11'h7FC, 11'h7FE, 8'd3, 1);
    wait_done(1, cyc);
    n_total++; if (cyc != exp_cycles(3)) $display("FAIL wrap_len: got %0d want %0d", cyc, exp_cycles(3)); else n_pass++;
    step();
    n_total++; if (q_addr.size() != 0 || q_lane.size() != 0)
      $display("FAIL wrap_drain: got %0d/%0d pending want 0/0", q_addr.size(), q_lane.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc, d0;
    launch(11'h040, 11'h300, 8'd20, 1);
    repeat (11) step();
    d0 = done_cnt;
    rst_n = 1'b0;
    q_addr.delete();
    q_lane.delete();
    step();
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0b want 0", busy); else n_pass++;
    n_total++; if (sram_cen !== 1'b1) $display("FAIL mid_cen: got %0b want 1", sram_cen); else n_pass++;
    n_total++; if (inst_w !== '0 || in_w !== '0)
      $display("FAIL mid_west: got inst_w %0h in_w %0h want 0 0", inst_w, in_w); else n_pass++;
    rst_n = 1'b1;
    repeat (40) step();
    n_total++; if (done_cnt != d0) $display("FAIL mid_no_done: got %0d want %0d", done_cnt, d0); else n_pass++;
    launch(11'h050, 11'h180, 8'd5, 1);
    wait_done(1, cyc);
    n_total++; if (cyc != exp_cycles(5)) $display("FAIL mid_rerun_len: got %0d want %0d", cyc, exp_cycles(5)); else n_pass++;
    step();
    n_total++; if (q_addr.size() != 0 || q_lane.size() != 0)
      $display("FAIL mid_rerun_drain: got %0d/%0d pending want 0/0", q_addr.size(), q_lane.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_zero_len();
    test_start_filter();
    test_wrap();
    test_reset_mid();
    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
